// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_port_arbiter_if : requester and unified-memory bus signals of the arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // Instruction fetch requester
   logic            IFReq;
   logic [AW-1:0]   IFAddr;
   logic            IFCancel;
   logic [DW-1:0]   IFRData;
   logic            IFAck;

   // EXWM load/store requester
   logic            EXWMReq;
   logic            EXWMWE;
   logic [AW-1:0]   EXWMAddr;
   logic [DW-1:0]   EXWMWData;
   logic [DW/8-1:0] EXWMBE;
   logic [DW-1:0]   EXWMRData;
   logic            EXWMAck;
   logic            BusErr;

   // Single-port memory bus
   logic            MemReq;
   logic            MemWE;
   logic [AW-1:0]   MemAddr;
   logic [DW-1:0]   MemWData;
   logic [DW/8-1:0] MemBE;
   logic [DW-1:0]   MemRData;
   logic            MemReady;

   modport master (
      input  IFReq, IFAddr, IFCancel,
      output IFRData, IFAck,
      input  EXWMReq, EXWMWE, EXWMAddr, EXWMWData, EXWMBE,
      output EXWMRData, EXWMAck, BusErr,
      output MemReq, MemWE, MemAddr, MemWData, MemBE,
      input  MemRData, MemReady
   );

   modport slave (
      output IFReq, IFAddr, IFCancel,
      input  IFRData, IFAck,
      output EXWMReq, EXWMWE, EXWMAddr, EXWMWData, EXWMBE,
      input  EXWMRData, EXWMAck, BusErr,
      input  MemReq, MemWE, MemAddr, MemWData, MemBE,
      output MemRData, MemReady
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between fetch and load/store
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic               CLK,
   input  logic               rst_n,
   mem_port_arbiter_if.master bus
);

   localparam int          BW           = DW / 8;
   localparam logic [3:0]  STARVE_LIM   = 4'(STARVE_MAX);
   localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IBUS = 2'd1,
      DBUS = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t          state_q,   state_d;
   logic [3:0]      starve_q,  starve_d;
   logic [7:0]      wait_q,    wait_d;
   logic            cancel_q,  cancel_d;
   logic            err_q,     err_d;
   logic            gnt_if_q,  gnt_if_d;
   logic            we_q,      we_d;
   logic [AW-1:0]   addr_q,    addr_d;
   logic [DW-1:0]   wdata_q,   wdata_d;
   logic [BW-1:0]   be_q,      be_d;
   logic [DW-1:0]   rdata_q,   rdata_d;
   logic [DW-1:0]   if_hold_q, if_hold_d;
   logic [DW-1:0]   ex_hold_q, ex_hold_d;

   logic            mem_req;
   logic            if_ack;
   logic            ex_ack;
   logic            bus_err;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         wait_q    <= '0;
         cancel_q  <= 1'b0;
         err_q     <= 1'b0;
         gnt_if_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rdata_q   <= '0;
         if_hold_q <= '0;
         ex_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         wait_q    <= wait_d;
         cancel_q  <= cancel_d;
         err_q     <= err_d;
         gnt_if_q  <= gnt_if_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rdata_q   <= rdata_d;
         if_hold_q <= if_hold_d;
         ex_hold_q <= ex_hold_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      wait_d    = wait_q;
      cancel_d  = cancel_q;
      err_d     = err_q;
      gnt_if_d  = gnt_if_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      if_hold_d = if_hold_q;
      ex_hold_d = ex_hold_q;
      mem_req   = 1'b0;
      if_ack    = 1'b0;
      ex_ack    = 1'b0;
      bus_err   = 1'b0;

      case (state_q)
         IDLE: begin
            // EXWM has priority unless the fetch side has been starved too long
            if (bus.EXWMReq && !(bus.IFReq && (starve_q == STARVE_LIM))) begin
               state_d  = DBUS;
               gnt_if_d = 1'b0;
               we_d     = bus.EXWMWE;
               addr_d   = bus.EXWMAddr;
               wdata_d  = bus.EXWMWData;
               be_d     = bus.EXWMBE;
               wait_d   = '0;
               err_d    = 1'b0;
               if (!bus.IFReq)
                  starve_d = '0;
               else if (starve_q != STARVE_LIM)
                  starve_d = starve_q + 4'd1;
            end else if (bus.IFReq && !bus.IFCancel) begin
               state_d  = IBUS;
               gnt_if_d = 1'b1;
               we_d     = 1'b0;
               addr_d   = bus.IFAddr;
               be_d     = '1;
               wait_d   = '0;
               err_d    = 1'b0;
               starve_d = '0;
            end
         end

         IBUS, DBUS: begin
            mem_req = 1'b1;
            // A flushed fetch still has to run to completion on the bus
            if ((state_q == IBUS) && bus.IFCancel)
               cancel_d = 1'b1;
            if (bus.MemReady) begin
               rdata_d = bus.MemRData;
               state_d = RESP;
            end else if (TIMEOUT_EN && (wait_q == TIMEOUT_LAST)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else if (wait_q != 8'hFF) begin
               wait_d = wait_q + 8'd1;
            end
         end

         RESP: begin
            if (gnt_if_q) begin
               if_ack  = !cancel_q && !bus.IFCancel;
               bus_err = err_q && if_ack;
            end else begin
               ex_ack  = 1'b1;
               bus_err = err_q;
            end
            if (if_ack)
               if_hold_d = rdata_q;
            if (ex_ack)
               ex_hold_d = rdata_q;
            cancel_d = 1'b0;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Read data is presented straight from the capture register during the Ack
   // and held per port afterwards, so a suppressed Ack never disturbs it.
   assign bus.IFRData   = if_ack ? rdata_q : if_hold_q;
   assign bus.EXWMRData = ex_ack ? rdata_q : ex_hold_q;
   assign bus.IFAck     = if_ack;
   assign bus.EXWMAck   = ex_ack;
   assign bus.BusErr    = bus_err;
   assign bus.MemReq    = mem_req;
   assign bus.MemWE     = we_q;
   assign bus.MemAddr   = addr_q;
   assign bus.MemWData  = wdata_q;
   assign bus.MemBE     = be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : directed and randomized checks of mem_port_arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int STARVE_P  = 4;
   localparam int TIMEOUT_P = 8;

   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] if_hold = '0;
   logic [DW-1:0] ex_hold = '0;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_MAX(STARVE_P), .TIMEOUT(TIMEOUT_P)
   ) dut (
      .CLK  (CLK),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.IFReq = 0; bus.IFCancel = 0; bus.EXWMReq = 0;
      bus.MemReady = 0;
   endtask

   // One complete transaction; k = wait cycles before MemReady, cancel_at = -1
   // for none, else the bus cycle index (or n for the response cycle).
   task automatic txn(input bit is_if, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] rdata, input int k, input int cancel_at);
      int            n;
      bit            err;
      bit            exp_ack;
      logic [31:0]   exp_data;
      n        = (k < TIMEOUT_P) ? k + 1 : TIMEOUT_P;
      err      = (k >= TIMEOUT_P);
      exp_ack  = !(is_if && cancel_at >= 0);
      exp_data = err ? 32'h0 : rdata;

      tick();
      bus.MemReady = 0; bus.IFCancel = 0;
      if (is_if) begin
         bus.IFReq = 1; bus.IFAddr = addr; bus.EXWMReq = 0;
      end else begin
         bus.EXWMReq = 1; bus.EXWMWE = we; bus.EXWMAddr = addr;
         bus.EXWMWData = wdata; bus.EXWMBE = be; bus.IFReq = 0;
      end
      #1;
      check("idle_memreq", bus.MemReq, 0);

      for (int j = 0; j < n; j++) begin
         tick();
         bus.MemReady = (j == k);
         bus.MemRData = (j == k) ? rdata : $urandom;
         bus.IFCancel = is_if && (j == cancel_at);
         #1;
         check("bus_memreq", bus.MemReq, 1);
         check("bus_addr", bus.MemAddr, addr);
         check("bus_we", bus.MemWE, is_if ? 1'b0 : we);
         check("bus_be", bus.MemBE, is_if ? 4'hF : be);
         if (!is_if && we) check("bus_wdata", bus.MemWData, wdata);
         check("bus_acks", {bus.IFAck, bus.EXWMAck}, 2'b00);
      end

      tick();
      bus.MemReady = 1'($urandom);
      bus.MemRData = $urandom;
      bus.IFCancel = is_if && (cancel_at == n);
      #1;
      check("resp_memreq", bus.MemReq, 0);
      check("resp_ifack", bus.IFAck, is_if && exp_ack);
      check("resp_exack", bus.EXWMAck, !is_if);
      check("resp_buserr", bus.BusErr, err && exp_ack);
      if (exp_ack) begin
         if (is_if) if_hold = exp_data;
         else       ex_hold = exp_data;
      end
      check("resp_ifrdata", bus.IFRData, if_hold);
      check("resp_exrdata", bus.EXWMRData, ex_hold);

      tick();
      idle_inputs();
      bus.MemRData = $urandom;
      #1;
      check("post_memreq", bus.MemReq, 0);
      check("post_acks", {bus.IFAck, bus.EXWMAck, bus.BusErr}, 3'b000);
      check("post_ifrdata", bus.IFRData, if_hold);
      check("post_exrdata", bus.EXWMRData, ex_hold);
   endtask

   initial begin
      idle_inputs();
      bus.IFAddr = '0; bus.EXWMWE = 0; bus.EXWMAddr = '0;
      bus.EXWMWData = '0; bus.EXWMBE = '0; bus.MemRData = '0;

      // Reset state
      repeat (2) tick();
      #1;
      check("rst_memreq", bus.MemReq, 0);
      check("rst_acks", {bus.IFAck, bus.EXWMAck, bus.BusErr}, 3'b000);
      check("rst_fields", {bus.MemWE, bus.MemAddr, bus.MemBE}, '0);
      check("rst_rdata", {bus.IFRData, bus.EXWMRData}, '0);
      tick();
      rst_n = 1;

      // Single fetch, minimum latency
      txn(1, 0, 32'h100, 0, 4'h0, 32'h0000_0013, 0, -1);

      // Contention: both held, MemReady always high
      for (int c = 0; c < 30; c++) begin
         int m;
         bit slot_if;
         tick();
         if (c == 0) begin
            bus.IFReq = 1; bus.IFAddr = 32'h400;
            bus.EXWMReq = 1; bus.EXWMWE = 0; bus.EXWMAddr = 32'h8000;
            bus.EXWMBE = 4'hC; bus.MemReady = 1;
         end
         bus.MemRData = 32'hA000_0000 + c;
         #1;
         m = c / 3;
         slot_if = (m % (STARVE_P + 1)) == STARVE_P;
         check("cont_memreq", bus.MemReq, (c % 3) == 1);
         if ((c % 3) == 1) check("cont_addr", bus.MemAddr, slot_if ? 32'h400 : 32'h8000);
         check("cont_ifack", bus.IFAck, ((c % 3) == 2) && slot_if);
         check("cont_exack", bus.EXWMAck, ((c % 3) == 2) && !slot_if);
         if ((c % 3) == 2) begin
            if (slot_if) if_hold = 32'hA000_0000 + c - 1;
            else         ex_hold = 32'hA000_0000 + c - 1;
            check("cont_ifrdata", bus.IFRData, if_hold);
            check("cont_exrdata", bus.EXWMRData, ex_hold);
         end
      end
      tick();
      idle_inputs();
      #1;
      check("cont_end_memreq", bus.MemReq, 0);

      // Store with wait states
      txn(0, 1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 32'h1111_2222, 4, -1);
      // Cancel in flight, then a normal fetch
      txn(1, 0, 32'h104, 0, 4'h0, 32'hBAD0_BAD0, 2, 1);
      txn(1, 0, 32'h108, 0, 4'h0, 32'h0000_0093, 0, -1);
      // Cancel during the response cycle
      txn(1, 0, 32'h10C, 0, 4'h0, 32'h7777_7777, 1, 2);
      // Timeout, and MemReady exactly on the last allowed cycle
      txn(0, 0, 32'h3000, 0, 4'hF, 32'h5555_5555, 100, -1);
      txn(0, 0, 32'h3004, 0, 4'hF, 32'h6666_6666, TIMEOUT_P - 1, -1);
      txn(1, 0, 32'h200, 0, 4'h0, 32'h9999_9999, TIMEOUT_P, -1);

      // IFCancel in IDLE blocks the fetch grant
      tick();
      bus.IFReq = 1; bus.IFAddr = 32'h500; bus.IFCancel = 1;
      tick();
      idle_inputs();
      #1;
      check("idle_cancel_memreq", bus.MemReq, 0);

      // Reset in the middle of a data transaction
      tick();
      bus.EXWMReq = 1; bus.EXWMWE = 1; bus.EXWMAddr = 32'h6000;
      bus.EXWMWData = 32'h1234_5678; bus.EXWMBE = 4'hF;
      tick();
      #1;
      check("prerst_memreq", bus.MemReq, 1);
      tick();
      rst_n = 0;
      #1;
      check("midrst_memreq", bus.MemReq, 0);
      check("midrst_fields", {bus.MemWE, bus.MemAddr, bus.MemWData}, '0);
      check("midrst_ack", {bus.IFAck, bus.EXWMAck, bus.BusErr}, 3'b000);
      if_hold = '0; ex_hold = '0;
      tick();
      bus.EXWMReq = 0; bus.MemReady = 1;
      tick();
      rst_n = 1; bus.MemReady = 0;
      #1;
      check("postrst_memreq", bus.MemReq, 0);
      tick();
      #1;
      check("postrst_ack", {bus.IFAck, bus.EXWMAck}, 2'b00);
      check("postrst_rdata", {bus.IFRData, bus.EXWMRData}, '0);
      txn(1, 0, 32'h700, 0, 4'h0, 32'hCAFE_F00D, 1, -1);

      // Randomized single transactions
      for (int t = 0; t < 40; t++) begin
         bit is_if;
         int k, n, cancel_at;
         is_if = 1'($urandom);
         k = $urandom_range(0, TIMEOUT_P + 3);
         n = (k < TIMEOUT_P) ? k + 1 : TIMEOUT_P;
         cancel_at = (is_if && ($urandom_range(0, 3) == 0)) ? $urandom_range(0, n) : -1;
         txn(is_if, 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, k, cancel_at);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
